// File: rtl/lcd_timing_gen.sv
// Raster timing generator: h/v counters with registered sync, DE, coordinate and strobe outputs.
// Optional colour-bar source on o_rgb, enabled by defining LCD_TIMING_GEN_PATTERN_EN.
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int H_SYNC   = 10,
  parameter int H_BACK   = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 29,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int X_W      = 10,
  parameter int Y_W      = 10
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_de,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_sof,
  output logic           o_eol
`ifdef LCD_TIMING_GEN_PATTERN_EN
  ,output logic [23:0]   o_rgb
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // One extra bit so a total of exactly 2^W still compares correctly.
  localparam logic [X_W:0]   HA    = (X_W+1)'(H_ACTIVE);
  localparam logic [X_W:0]   HS0   = (X_W+1)'(H_ACTIVE + H_FRONT);
  localparam logic [X_W:0]   HS1   = (X_W+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [X_W:0]   HEOL  = (X_W+1)'(H_ACTIVE - 1);
  localparam logic [X_W-1:0] HLAST = X_W'(H_TOTAL - 1);
  localparam logic [Y_W:0]   VA    = (Y_W+1)'(V_ACTIVE);
  localparam logic [Y_W:0]   VS0   = (Y_W+1)'(V_ACTIVE + V_FRONT);
  localparam logic [Y_W:0]   VS1   = (Y_W+1)'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [Y_W-1:0] VLAST = Y_W'(V_TOTAL - 1);
  localparam logic           HSP   = 1'(HS_POL);
  localparam logic           VSP   = 1'(VS_POL);

  logic [X_W-1:0] h_q, h_d;
  logic [Y_W-1:0] v_q, v_d;
  logic [X_W:0]   hx;
  logic [Y_W:0]   vy;
  logic           h_wrap, de_d, hs_d, vs_d, sof_d, eol_d;

  always_comb begin
    hx     = {1'b0, h_q};
    vy     = {1'b0, v_q};
    h_wrap = (h_q == HLAST);
    h_d    = h_wrap ? '0 : h_q + 1'b1;
    v_d    = v_q;
    if (h_wrap) v_d = (v_q == VLAST) ? '0 : v_q + 1'b1;
    de_d   = (hx < HA) && (vy < VA);
    hs_d   = ((hx >= HS0) && (hx < HS1)) ? HSP : ~HSP;
    vs_d   = ((vy >= VS0) && (vy < VS1)) ? VSP : ~VSP;
    sof_d  = (h_q == '0) && (v_q == '0);
    eol_d  = (hx == HEOL) && (vy < VA);
  end

`ifdef LCD_TIMING_GEN_PATTERN_EN
  logic [2:0]  bar_d;
  logic [23:0] rgb_d;

  // Bar index = number of elaboration-time thresholds k*H_ACTIVE/8 already passed.
  always_comb begin
    bar_d = '0;
    for (int k = 1; k < 8; k++)
      if (hx >= (X_W+1)'(k * H_ACTIVE / 8)) bar_d = bar_d + 3'd1;
    case (bar_d)
      3'd0:    rgb_d = 24'hFFFFFF;
      3'd1:    rgb_d = 24'hFFFF00;
      3'd2:    rgb_d = 24'h00FFFF;
      3'd3:    rgb_d = 24'h00FF00;
      3'd4:    rgb_d = 24'hFF00FF;
      3'd5:    rgb_d = 24'hFF0000;
      3'd6:    rgb_d = 24'h0000FF;
      default: rgb_d = 24'h000000;
    endcase
    if (!de_d) rgb_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     o_rgb <= '0;
    else if (i_en) o_rgb <= rgb_d;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q     <= '0;
      v_q     <= '0;
      o_hsync <= ~HSP;
      o_vsync <= ~VSP;
      o_de    <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_sof   <= 1'b0;
      o_eol   <= 1'b0;
    end else if (i_en) begin
      h_q     <= h_d;
      v_q     <= v_d;
      o_hsync <= hs_d;
      o_vsync <= vs_d;
      o_de    <= de_d;
      o_x     <= h_q;
      o_y     <= v_q;
      o_sof   <= sof_d;
      o_eol   <= eol_d;
    end else begin
      // Strobes are one clock wide even when the pixel rate is divided.
      o_sof   <= 1'b0;
      o_eol   <= 1'b0;
    end
  end

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Parametrised raster timing generator for the LCD panel path: a combined horizontal/vertical counter pair that produces hsync, vsync, data-enable, pixel coordinates and frame/line strobes for any panel geometry. It replaces the fixed 800-pixel horizontal-only generator and sits between the pixel clock domain and the pixel source / panel driver. A clock-enable input allows a pixel rate below the system clock. An optional colour-bar source supports panel bring-up.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 10, hsync width (pixels)
- H_BACK, 40, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 13, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BACK, 29, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active low)
- VS_POL, 0, vsync active level
- X_W, 10, width of the x counter; requires H_ACTIVE+H_FRONT+H_SYNC+H_BACK ≤ 2^X_W
- Y_W, 10, width of the y counter; same rule for vertical total

- i_clk  in  1  system/pixel clock, rising edge
- i_rst  in  1  synchronous reset, active high
- i_en  in  1  pixel enable; counters advance only when high
- o_hsync  out  1  horizontal sync at HS_POL
- o_vsync  out  1  vertical sync at VS_POL
- o_de  out  1  data enable, high inside the active area
- o_x  out  X_W  horizontal counter value (0 .. H_TOTAL-1, not clamped)
- o_y  out  Y_W  vertical counter value (0 .. V_TOTAL-1)
- o_sof  out  1  start-of-frame strobe
- o_eol  out  1  end-of-active-line strobe
- o_rgb  out  24  colour bars, {R,G,B}; present only with the macro

## Operation
- H_TOTAL = sum of the four H parameters; V_TOTAL likewise. Horizontal region order: active, front porch, sync, back porch. Vertical order is the same.
- h counter: 0 .. H_TOTAL-1, wraps to 0. v counter increments on h wrap and wraps to 0 after V_TOTAL-1.
- Sync decode:
  - hsync is active for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - vsync is active for whole lines v in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC), changing at h = 0.
- de = (h < H_ACTIVE) && (v < V_ACTIVE).
- sof = (h == 0 && v == 0). eol = (h == H_ACTIVE-1 && v < V_ACTIVE).
- i_en low:
  - counters hold;
  - hsync, vsync, de, x, y and rgb hold their values;
  - o_sof and o_eol are driven 0, so strobes are exactly one clock wide.
- Arithmetic is unsigned. Boundary constants are elaboration-time. No runtime division.

## Timing
- All outputs are registered. On an edge with i_en=1, the outputs load the decode of the current counter state and the counters advance. Output latency is therefore one clock after the enabled cycle.
- Reset (i_rst=1 at an edge, regardless of i_en):
  - h = v = 0;
  - o_hsync = ~HS_POL, o_vsync = ~VS_POL;
  - o_de = 0, o_x = 0, o_y = 0, o_sof = 0, o_eol = 0, o_rgb = 0.
- First enabled edge after reset release: o_sof=1, o_de=1, o_x=0, o_y=0.
- Reset mid-frame aborts the frame immediately; there is no partial-line completion.
- Frame period is H_TOTAL·V_TOTAL enabled cycles. o_sof occurs once per frame.

## Configuration
- LCD_TIMING_GEN_PATTERN_EN defined: adds o_rgb.
  - The active width is split into 8 bars with thresholds k·H_ACTIVE/8, k = 1..7, evaluated at elaboration.
  - Colours left to right: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - o_rgb = 0 when de is 0. It is registered and aligned with o_de.
- Undefined: o_rgb port and its logic are absent; all other behaviour is identical.

## Test plan
Small geometry for all tests: H 8/2/1/2 (H_TOTAL 13), V 4/1/1/1 (V_TOTAL 7), HS_POL=VS_POL=0, i_en=1 unless stated.
- Reset: hold i_rst for 3 clocks -> o_hsync=1, o_vsync=1, o_de=0, o_x=o_y=0, o_sof=0. First edge after release -> o_sof=1, o_de=1, x=0.
- Line: o_de is high for 8 consecutive clocks (x 0..7), o_eol at x=7, o_hsync low only at x=10, period 13. Rerun with HS_POL=1 -> hsync high only at x=10.
- Frame: o_vsync low for exactly 13 clocks while y=5. o_de is never high for y ≥ 4. o_sof every 91 clocks.
- Enable gating: i_en toggles 1,0,1,0… -> o_sof period 182 clocks, each o_sof 1 clock wide, o_x steps once per 2 clocks.
- Reset mid-frame: assert i_rst at x=5, y=2 -> after release, o_x/o_y restart at 0/0 with o_sof=1, and no stale hsync or vsync.
- Pattern (macro defined): x=0..7 on y=0 -> o_rgb FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; x=8 -> 000000 with o_de=0.
